// File: rtl/tl_pkg.sv
// Shared encodings for the two-road, four-phase traffic-light scheduler.
// Also holds the cyclic next-phase selector.
package tl_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] LEFT   = 2'b11;

  localparam logic [1:0] AS = 2'd0;
  localparam logic [1:0] AL = 2'd1;
  localparam logic [1:0] BS = 2'd2;
  localparam logic [1:0] BL = 2'd3;

  typedef enum logic [1:0] {
    GRN  = 2'd0,
    YEL  = 2'd1,
    ARED = 2'd2
  } state_e;

  // First requested phase after cur in AS->AL->BS->BL order; cur if none requested.
  function automatic logic [1:0] next_phase(input logic [1:0] cur, input logic [3:0] req);
    logic [1:0] cand;
    next_phase = cur;
    // Walk from the farthest candidate inward so the nearest requested one wins.
    for (int i = 3; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (req[cand]) next_phase = cand;
    end
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Saturating up-counter with synchronous clear.
// One instance times green, yellow and all-red.
module tl_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      count_q <= '0;
    end else if (count_q != {CNT_W{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tl_phase_sched.sv
// Four-phase traffic-light scheduler: green/left -> yellow -> all-red, with the
// next phase chosen by cyclic priority among requesting sensors.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YEL_T     = 2,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [1:0] phase,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MinLast = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxLast = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YelLast = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] ArdLast = CNT_W'(ALLRED_T - 1);

  localparam bit ParamsOk = (MIN_GREEN >= 1) && (MAX_GREEN >= MIN_GREEN) && (YEL_T >= 1) &&
                            (ALLRED_T >= 1) &&
                            (longint'(MAX_GREEN) < (64'd1 << CNT_W)) &&
                            (longint'(YEL_T) < (64'd1 << CNT_W)) &&
                            (longint'(ALLRED_T) < (64'd1 << CNT_W));

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       next_ph_q, next_ph_d;
  logic [1:0]       la_q, la_d, lb_q, lb_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] timer;
  logic             timer_clr;
  logic [3:0]       req;
  logic             own_req, other_req;

  tl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (timer_clr),
    .count_o (timer)
  );

  assign req       = {Tbl, Tb, Tal, Ta};
  assign own_req   = req[phase_q];
  assign other_req = |(req & ~(4'b0001 << phase_q));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    next_ph_d = next_ph_q;
    unique case (state_q)
      GRN: begin
        if (timer >= MinLast && other_req && (!own_req || timer >= MaxLast)) begin
          state_d   = YEL;
          next_ph_d = next_phase(phase_q, req);
        end
      end
      YEL: begin
        if (timer == YelLast) state_d = ARED;
      end
      ARED: begin
        if (timer == ArdLast) begin
          state_d = GRN;
          phase_d = next_ph_q;
        end
      end
      default: state_d = GRN;
    endcase
  end

  // Phase only changes together with a state change, so one compare covers both.
  assign timer_clr = (state_d != state_q);

  // Lamps are decoded from next state so they register on the same edge as the state.
  always_comb begin
    la_d   = RED;
    lb_d   = RED;
    busy_d = (state_d != GRN);
    unique case (state_d)
      GRN: begin
        if (!phase_d[1]) la_d = phase_d[0] ? LEFT : GREEN;
        else             lb_d = phase_d[0] ? LEFT : GREEN;
      end
      YEL: begin
        if (!phase_d[1]) la_d = YELLOW;
        else             lb_d = YELLOW;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= GRN;
      phase_q   <= AS;
      next_ph_q <= AS;
      la_q      <= GREEN;
      lb_q      <= RED;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      next_ph_q <= next_ph_d;
      la_q      <= la_d;
      lb_q      <= lb_d;
      busy_q    <= busy_d;
    end
  end

  assign La    = la_q;
  assign Lb    = lb_q;
  assign phase = phase_q;
  assign busy  = busy_q;

  param_legal: assert property (@(posedge clk) ParamsOk);

endmodule

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
- Four-phase traffic-light scheduler for a two-road intersection with protected left turns.
- Phases: A straight, A left, B straight, B left.
- Sequences each green through yellow and all-red, using cycle-count timers.
- Picks the next phase by cyclic priority, skipping unrequested phases, from the vehicle sensors Ta, Tal, Tb, Tbl.
- Drives the 2-bit lamp codes La, Lb consumed by the intersection lamp drivers.

Parameters:
- CNT_W, 8, timer counter width.
- MIN_GREEN, 4, minimum cycles any green or left phase is held.
- MAX_GREEN, 12, maximum green cycles while a competing request is pending.
- YEL_T, 2, yellow duration in cycles.
- ALLRED_T, 1, all-red clearance duration in cycles.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Ta  input  1  vehicle present, road A straight.
- Tal  input  1  vehicle present, road A left-turn lane.
- Tb  input  1  vehicle present, road B straight.
- Tbl  input  1  vehicle present, road B left-turn lane.
- La  output  2  road A lamp code.
- Lb  output  2  road B lamp code.
- phase  output  2  current or last-served phase.
- busy  output  1  high during yellow and all-red.

Behaviour:
- Encodings:
  - Lamp: GREEN=2'b00, YELLOW=2'b01, RED=2'b10, LEFT=2'b11.
  - Phase: AS=0, AL=1, BS=2, BL=3.
- Reset (synchronous, sampled on the clk edge, wins over everything):
  - state=GRN, phase=AS, timer=0, next_ph=AS.
  - La=GREEN, Lb=RED, busy=0, all effective the cycle after reset is sampled high.
- States: GRN, YEL, ARED. The phase register qualifies which road and movement is served.
- Lamp outputs, registered (they change in the same edge as the state):
  - GRN: the served road shows GREEN (AS/BS) or LEFT (AL/BL); the other road shows RED.
  - YEL: the served road shows YELLOW; the other road shows RED.
  - ARED: La=Lb=RED.
- Timer:
  - Clears to 0 on every state or phase change.
  - Otherwise increments by 1 per cycle and saturates at 2^CNT_W-1 (no wrap).
- Sensor mapping: own_req is the sensor of the current phase (AS:Ta, AL:Tal, BS:Tb, BL:Tbl). other_req is the OR of the other three sensors.
- GRN -> YEL when all of the following hold:
  - timer >= MIN_GREEN-1;
  - other_req = 1;
  - own_req = 0, or timer >= MAX_GREEN-1.
  - On that same edge, next_ph is latched as the first requested phase in cyclic order after the current phase (AS->AL->BS->BL->AS).
- No other_req: remain in GRN indefinitely and hold the timer saturated; MAX_GREEN does not force a change.
- YEL -> ARED when timer = YEL_T-1, so yellow lasts exactly YEL_T cycles.
- ARED -> GRN when timer = ALLRED_T-1. On that edge phase<=next_ph.
  - next_ph is not re-evaluated during YEL or ARED; requests that drop in that window are still served for MIN_GREEN cycles.
- busy=1 in YEL and ARED; 0 in GRN.
- Simultaneous requests are resolved only by the cyclic order.
- Sensors are assumed synchronous to clk; no synchronizer is inside the block.
- Parameter legality (simulation assertion): MIN_GREEN>=1, MAX_GREEN>=MIN_GREEN, YEL_T>=1, ALLRED_T>=1, all values < 2^CNT_W.

Decomposition:
- Package tl_pkg:
  - lamp code constants GREEN/YELLOW/RED/LEFT;
  - phase codes AS/AL/BS/BL;
  - state encoding GRN/YEL/ARED;
  - function next_phase(cur, req[3:0]) returning the first requested phase in cyclic order.
- Sub-module tl_timer: saturating counter (CNT_W) with synchronous clear. Used once for all three states.

Test Plan:
- Reset, all sensors 0, run 30 cycles -> La=00, Lb=10, phase=0, busy=0 throughout.
- Tb=1 only, held from reset release -> A green 4 cycles, La=01 for 2 cycles, La=Lb=10 for 1 cycle, then Lb=00, La=10, phase=2.
- Ta=1 and Tb=1 held -> A green exactly 12 cycles (MAX_GREEN) before La=01; B then holds 12 cycles and returns to A via AL/BL skipping.
- Tal=1, Tb=1 while in AS green, Ta=0 -> next served phase is AL: La=11, Lb=10, phase=1, held >=4 cycles.
- Only Tbl=1 while in AS green -> AL and BS skipped: after yellow/all-red, Lb=11, La=10, phase=3.
- reset pulsed high for 1 cycle during YEL -> next cycle La=00, Lb=10, phase=0, busy=0, timer restarts at 0.
